rx_bert_lanes: RTL

Multi-lane receive-side bit-error-rate tester with automatic per-lane PRBS lock acquisition and loss-of-lock recovery. Each of `Lanes` deserialized lanes gets its own self-seeding PRBS checker, lock state machine, saturating error counter and relock counter. A shared bit counter feeds a programmable shutoff. The block sits after the per-lane deserializers and is configured and read through scan/config registers.

---
 rtl/rx_bert_pkg.sv | 29 ++
 rtl/rx_bert_lane.sv | 135 +++++++++++++
 rtl/rx_bert_lanes.sv | 93 +++++++++
 3 files changed

// File: rtl/rx_bert_pkg.sv
// Shared types and constants for the multi-lane receive BERT.
// Holds the lane state encoding, PRBS tap lookup and shutoff bit positions.
package rx_bert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } lane_state_e;

    localparam int ShutoffBit0 = 10;
    localparam int ShutoffBit1 = 20;
    localparam int ShutoffBit2 = 30;
    localparam int ShutoffBit3 = 40;

    localparam int RelockWidth = 8;

    // Second tap m of x^n + x^m + 1 for the supported PRBS orders.
    function automatic int prbs_tap(input int length);
        case (length)
            7:       return 6;
            15:      return 14;
            23:      return 18;
            default: return 28;
        endcase
    endfunction

endpackage

// File: rtl/rx_bert_lane.sv
// One BERT lane: self-seeding PRBS checker, lock FSM, saturating error
// counter and relock counter. The FSM state is exposed for observation.
module rx_bert_lane
    import rx_bert_pkg::*;
#(
    parameter int LaneWidth  = 8,
    parameter int PRBSLength = 31,
    parameter int CountWidth = 41,
    parameter int LockThresh = 16,
    parameter int LossThresh = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   lane_en,
    input  logic                   cnt_act,
    input  logic                   clear,
    input  logic [LaneWidth-1:0]   data,
    output logic                   lock,
    output logic [CountWidth-1:0]  err_count,
    output logic [RelockWidth-1:0] relock_count,
    output lane_state_e            state
);

    localparam int Tap        = prbs_tap(PRBSLength);
    localparam int SeedCycles = (PRBSLength + LaneWidth - 1) / LaneWidth;
    localparam int SeedW      = $clog2(SeedCycles) + 1;
    localparam int LockW      = $clog2(LockThresh) + 1;
    localparam int LossW      = $clog2(LossThresh) + 1;
    localparam int PopW       = $clog2(LaneWidth + 1);

    logic [PRBSLength-1:0] lfsr;
    logic [PRBSLength-1:0] lfsr_seed;
    logic [PRBSLength-1:0] lfsr_gen;
    logic [LaneWidth-1:0]  gen_word;
    logic [LaneWidth-1:0]  err_vec;
    logic [PopW-1:0]       pop;
    logic                  word_err;
    logic [CountWidth:0]   err_sum;
    logic [CountWidth-1:0] err_next;
    logic [SeedW-1:0]      seed_cnt;
    logic [LockW-1:0]      clean_cnt;
    logic [LossW-1:0]      err_run;

    // lfsr[0] is the newest bit; data bit 0 is the oldest serial bit.
    always_comb begin
        lfsr_seed = lfsr;
        lfsr_gen  = lfsr;
        gen_word  = '0;
        for (int i = 0; i < LaneWidth; i++) begin
            lfsr_seed   = {lfsr_seed[PRBSLength-2:0], data[i]};
            gen_word[i] = lfsr_gen[PRBSLength-1] ^ lfsr_gen[Tap-1];
            lfsr_gen    = {lfsr_gen[PRBSLength-2:0], gen_word[i]};
        end
        err_vec  = gen_word ^ data;
        word_err = |err_vec;
        pop      = '0;
        for (int i = 0; i < LaneWidth; i++) begin
            pop = pop + PopW'(err_vec[i]);
        end
        err_sum  = {1'b0, err_count} + (CountWidth + 1)'(pop);
        err_next = err_sum[CountWidth] ? '1 : err_sum[CountWidth-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            lock         <= 1'b0;
            lfsr         <= '0;
            seed_cnt     <= '0;
            clean_cnt    <= '0;
            err_run      <= '0;
            err_count    <= '0;
            relock_count <= '0;
        end else if (en) begin
            if (clear) begin
                err_count    <= '0;
                relock_count <= '0;
            end else if (state == ST_LOCKED && cnt_act) begin
                err_count <= err_next;
            end

            if (!lane_en) begin
                state <= ST_IDLE;
                lock  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_SEED;
                        seed_cnt <= '0;
                    end
                    ST_SEED: begin
                        lfsr <= lfsr_seed;
                        if (seed_cnt == SeedW'(SeedCycles - 1)) begin
                            state     <= ST_CHECK;
                            clean_cnt <= '0;
                        end else begin
                            seed_cnt <= seed_cnt + SeedW'(1);
                        end
                    end
                    ST_CHECK: begin
                        lfsr <= lfsr_gen;
                        if (word_err) begin
                            state    <= ST_SEED;
                            seed_cnt <= '0;
                        end else if (clean_cnt == LockW'(LockThresh - 1)) begin
                            state   <= ST_LOCKED;
                            lock    <= 1'b1;
                            err_run <= '0;
                        end else begin
                            clean_cnt <= clean_cnt + LockW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        lfsr <= lfsr_gen;
                        if (!word_err) begin
                            err_run <= '0;
                        end else if (err_run == LossW'(LossThresh - 1)) begin
                            state    <= ST_SEED;
                            lock     <= 1'b0;
                            seed_cnt <= '0;
                            if (!clear && relock_count != '1) begin
                                relock_count <= relock_count + RelockWidth'(1);
                            end
                        end else begin
                            err_run <= err_run + LossW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/rx_bert_lanes.sv
// Multi-lane receive BERT: input register, count gating, shared bit counter
// with programmable shutoff, and one rx_bert_lane per lane.
module rx_bert_lanes
    import rx_bert_pkg::*;
#(
    parameter int Lanes      = 4,
    parameter int LaneWidth  = 8,
    parameter int PRBSLength = 31,
    parameter int CountWidth = 41,
    parameter int LockThresh = 16,
    parameter int LossThresh = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [Lanes*LaneWidth-1:0]   i_data_in,
    input  logic [Lanes-1:0]             i_cfg_lane_en,
    input  logic                         i_cfg_data_inv,
    input  logic                         i_cfg_count_en,
    input  logic                         i_cfg_clear,
    input  logic [3:0]                   i_cfg_shutoff_sel,
    output logic [Lanes-1:0]             o_lock,
    output logic [Lanes*CountWidth-1:0]  o_err_count,
    output logic [Lanes*RelockWidth-1:0] o_relock_count,
    output logic [CountWidth-1:0]        o_bit_count,
    output logic                         o_shutoff,
    output logic [Lanes*2-1:0]           o_lane_state
);

    localparam logic [CountWidth-1:0] BitStep  = CountWidth'(LaneWidth);
    localparam logic [CountWidth-1:0] BitLimit = {CountWidth{1'b1}} - BitStep;

    logic [Lanes*LaneWidth-1:0] data_q;
    logic                       cnt_act;
    logic                       shutoff_hit;
    logic [CountWidth-1:0]      bit_next;

    always_comb begin
        bit_next    = (o_bit_count > BitLimit) ? '1 : o_bit_count + BitStep;
        shutoff_hit = |(i_cfg_shutoff_sel & {o_bit_count[ShutoffBit3], o_bit_count[ShutoffBit2],
                                             o_bit_count[ShutoffBit1], o_bit_count[ShutoffBit0]});
    end

    // The bit counter also honours o_shutoff directly so it stops after
    // exactly one step past the selected bit, one cycle before cnt_act falls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q      <= '0;
            cnt_act     <= 1'b0;
            o_bit_count <= '0;
            o_shutoff   <= 1'b0;
        end else if (i_en) begin
            data_q  <= i_data_in ^ {(Lanes * LaneWidth){i_cfg_data_inv}};
            cnt_act <= i_cfg_count_en & ~o_shutoff;
            if (i_cfg_clear) begin
                o_bit_count <= '0;
                o_shutoff   <= 1'b0;
            end else begin
                if (cnt_act && !o_shutoff) begin
                    o_bit_count <= bit_next;
                end
                o_shutoff <= o_shutoff | shutoff_hit;
            end
        end
    end

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        lane_state_e lane_state;

        rx_bert_lane #(
            .LaneWidth (LaneWidth),
            .PRBSLength(PRBSLength),
            .CountWidth(CountWidth),
            .LockThresh(LockThresh),
            .LossThresh(LossThresh)
        ) u_lane (
            .clk         (i_clk),
            .rst         (i_rst),
            .en          (i_en),
            .lane_en     (i_cfg_lane_en[g]),
            .cnt_act     (cnt_act),
            .clear       (i_cfg_clear),
            .data        (data_q[g*LaneWidth +: LaneWidth]),
            .lock        (o_lock[g]),
            .err_count   (o_err_count[g*CountWidth +: CountWidth]),
            .relock_count(o_relock_count[g*RelockWidth +: RelockWidth]),
            .state       (lane_state)
        );

        assign o_lane_state[g*2 +: 2] = lane_state;
    end

endmodule
